key_onehot_scanner: RTL



---
 rtl/key_onehot_scanner_pkg.sv | 14 +
 rtl/key_onehot_scanner_sync2.sv | 24 ++
 rtl/key_onehot_scanner.sv | 105 ++++++++++
 3 files changed

// File: rtl/key_onehot_scanner_pkg.sv
// Shared types and widths for the debounced one-hot key scanner.
// The scanner feeds an 8-to-3 encoder, so the key width is fixed at 8.
package key_scan_pkg;

   localparam int KEY_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_DB,
      HELD,
      RELEASE_DB
   } scan_state_t;

endpackage

// File: rtl/key_onehot_scanner_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous key lines.
// Each bit is synchronized independently; multi-bit skew is absorbed by the debouncer.
module key_sync2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_onehot_scanner.sv
// Debounced 8-key front end with n-key lockout: emits a stable one-hot key plus
// enable, a one-cycle press pulse, and a flag while a multi-key pattern is held.
module key_onehot_scanner
   import key_scan_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] keys_raw,
   output logic [KEY_W-1:0] onehot,
   output logic             en,
   output logic             press_pulse,
   output logic             multi_key
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   scan_state_t      state;
   logic [KEY_W-1:0] keys_s;
   logic [KEY_W-1:0] cand;
   logic [CNT_W-1:0] cnt;
   logic             cand_is_onehot;

   key_sync2 #(
      .WIDTH(KEY_W)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (keys_raw),
      .q    (keys_s)
   );

   assign cand_is_onehot = (cand != '0) && ((cand & (cand - 8'd1)) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cand        <= '0;
         cnt         <= '0;
         onehot      <= '0;
         en          <= 1'b0;
         press_pulse <= 1'b0;
         multi_key   <= 1'b0;
      end else begin
         press_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (keys_s != '0) begin
                  cand  <= keys_s;
                  cnt   <= '0;
                  state <= PRESS_DB;
               end
            end

            PRESS_DB: begin
               if (keys_s == '0) begin
                  state <= IDLE;
               end else if (keys_s != cand) begin
                  cand <= keys_s;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  if (cand_is_onehot) begin
                     onehot      <= cand;
                     en          <= 1'b1;
                     press_pulse <= 1'b1;
                     state       <= HELD;
                  end else begin
                     // Restart the count so the lockout still needs a full run of zeros.
                     multi_key <= 1'b1;
                     cnt       <= '0;
                     state     <= RELEASE_DB;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            HELD: begin
               if (keys_s != onehot) begin
                  cnt   <= '0;
                  state <= RELEASE_DB;
               end
            end

            RELEASE_DB: begin
               if (keys_s != '0) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  onehot    <= '0;
                  en        <= 1'b0;
                  multi_key <= 1'b0;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
